// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate cache controller for the 16-bit
// MIPS memory stage, with valid/tag arrays, flush, and saturating hit/miss counters.
module dm_cache_ctrl #(
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int INDEX_W = 8,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [1:0]        state_dbg
);

  localparam int TAG_W = ADDR_W - INDEX_W;
  localparam int LINES = 1 << INDEX_W;

  // CPU handshake: cpu_req with cpu_we/cpu_addr/cpu_wdata is held stable until the
  // cycle in which cpu_ready is high; that cycle completes the access.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FILL  = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_arr  [LINES];
  logic [DATA_W-1:0] data_arr [LINES];

  logic [INDEX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0]   tag, fill_tag;
  logic               hit, miss;
  logic               start_fill, start_write, fill_done, write_done;

  assign idx      = cpu_addr[INDEX_W-1:0];
  assign tag      = cpu_addr[ADDR_W-1:INDEX_W];
  // The outstanding memory address names the line being refilled.
  assign fill_idx = mem_addr[INDEX_W-1:0];
  assign fill_tag = mem_addr[ADDR_W-1:INDEX_W];

  assign hit  = cpu_req && (state == IDLE) && !flush && valid[idx] && (tag_arr[idx] == tag);
  assign miss = cpu_req && (state == IDLE) && !flush && !hit;

  assign cpu_rdata = data_arr[idx];
  assign state_dbg = state;

  always_comb begin
    state_nxt   = state;
    cpu_ready   = 1'b0;
    start_fill  = 1'b0;
    start_write = 1'b0;
    fill_done   = 1'b0;
    write_done  = 1'b0;
    case (state)
      IDLE: begin
        if (cpu_req && !flush) begin
          if (cpu_we) begin
            start_write = 1'b1;
            state_nxt   = WRITE;
          end else if (hit) begin
            cpu_ready = 1'b1;
          end else begin
            start_fill = 1'b1;
            state_nxt  = FILL;
          end
        end
      end
      FILL: begin
        if (mem_ack) begin
          fill_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      WRITE: begin
        if (mem_ack) begin
          cpu_ready  = 1'b1;
          write_done = 1'b1;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      valid     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      state <= state_nxt;

      if ((state == IDLE) && flush)
        valid <= '0;
      else if (fill_done)
        valid[fill_idx] <= 1'b1;

      if (start_fill || start_write) begin
        mem_req   <= 1'b1;
        mem_we    <= start_write;
        mem_addr  <= cpu_addr;
        mem_wdata <= cpu_wdata;
      end else if (fill_done || write_done) begin
        mem_req <= 1'b0;
        mem_we  <= 1'b0;
      end

      if (hit && (hit_cnt != '1))
        hit_cnt <= hit_cnt + CNT_W'(1);
      if (miss && (miss_cnt != '1))
        miss_cnt <= miss_cnt + CNT_W'(1);
    end
  end

  // Reset leaves state IDLE with all lines invalid, so neither write enable can fire
  // while rst is high; the arrays need no reset term.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_arr[fill_idx] <= mem_rdata;
      tag_arr[fill_idx]  <= fill_tag;
    end else if (hit && cpu_we) begin
      data_arr[idx] <= cpu_wdata;
    end
  end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Randomised scoreboard bench for dm_cache_ctrl: a line-level cache model plus a
// flat memory model predict latency, read data, memory traffic and counters.
module tb_dm_cache_ctrl;
  localparam int DATA_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int INDEX_W = 8;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic              clk, rst;
  logic              cpu_req, cpu_we, flush;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata, cpu_rdata;
  logic              cpu_ready;
  logic              mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic [CNT_W-1:0]  hit_cnt, miss_cnt;
  logic [1:0]        state_dbg;

  dm_cache_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .INDEX_W(INDEX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- scoreboard queues ----------------
  logic [DATA_W:0]        exp_q[$];   // {we, read data}
  logic [ADDR_W+DATA_W:0] mem_q[$];   // {we, addr, wdata}

  // ---------------- reference model ----------------
  bit                m_valid [256];
  logic [7:0]        m_tag   [256];
  logic [DATA_W-1:0] ref_mem [logic [ADDR_W-1:0]];
  logic [DATA_W-1:0] dev_mem [logic [ADDR_W-1:0]];
  int                m_hit = 0;
  int                m_miss = 0;

  function automatic logic [DATA_W-1:0] init_val(input logic [ADDR_W-1:0] a);
    return {a[7:0], a[15:8]} ^ 16'h5A3C;
  endfunction

  function automatic logic [DATA_W-1:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  function automatic logic [DATA_W-1:0] dev_rd(input logic [ADDR_W-1:0] a);
    return dev_mem.exists(a) ? dev_mem[a] : init_val(a);
  endfunction

  function automatic int sat(input int x);
    return (x > CNT_MAX) ? CNT_MAX : x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- memory device ----------------
  int mem_delay = 2;
  bit mem_hold  = 1'b0;
  int mem_cnt   = 0;

  always @(negedge clk) begin
    if (rst) begin
      mem_ack = 1'b0;
      mem_cnt = 0;
    end else if (mem_ack) begin
      mem_ack = 1'b0;
      mem_cnt = 0;
    end else if (mem_req && !mem_hold) begin
      mem_cnt++;
      if (mem_cnt >= mem_delay) begin
        mem_ack = 1'b1;
        if (mem_we) dev_mem[mem_addr] = mem_wdata;
        else        mem_rdata = dev_rd(mem_addr);
      end
    end
  end

  // ---------------- monitors ----------------
  logic prev_req = 1'b0;
  always @(negedge clk) begin
    logic [ADDR_W+DATA_W:0] m;
    #2;
    if (!rst && mem_req && !prev_req) begin
      if (mem_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_mem_req addr=%0h we=%0b required=none", mem_addr, mem_we);
      end else begin
        m = mem_q.pop_front();
        check("mem_we", 32'(mem_we), 32'(m[32]));
        check("mem_addr", 32'(mem_addr), 32'(m[31:16]));
        if (m[32]) check("mem_wdata", 32'(mem_wdata), 32'(m[15:0]));
      end
    end
    prev_req = mem_req;
  end

  always @(negedge clk) begin
    logic [DATA_W:0] e;
    #2;
    if (!rst && cpu_ready) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_cpu_ready addr=%0h required=none", cpu_addr);
      end else begin
        e = exp_q.pop_front();
        check("cpu_we_at_ready", 32'(cpu_we), 32'(e[DATA_W]));
        if (!e[DATA_W]) check("cpu_rdata", 32'(cpu_rdata), 32'(e[DATA_W-1:0]));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic access(input logic we, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] wd, input int dly);
    logic [7:0] idx, tg;
    bit h;
    int cyc, exp_cyc;
    idx = addr[7:0];
    tg  = addr[15:8];
    h   = m_valid[idx] && (m_tag[idx] == tg);
    if (we) begin
      ref_mem[addr] = wd;
      mem_q.push_back({1'b1, addr, wd});
      exp_q.push_back({1'b1, 16'h0});
      exp_cyc = dly;
      if (h) m_hit = sat(m_hit + 1);
      else   m_miss = sat(m_miss + 1);
    end else if (h) begin
      exp_q.push_back({1'b0, ref_rd(addr)});
      exp_cyc = 0;
      m_hit = sat(m_hit + 1);
    end else begin
      mem_q.push_back({1'b0, addr, 16'h0});
      exp_q.push_back({1'b0, ref_rd(addr)});
      exp_cyc = dly + 1;
      m_miss = sat(m_miss + 1);
      m_hit  = sat(m_hit + 1);   // the completing cycle is a read hit
      m_valid[idx] = 1'b1;
      m_tag[idx]   = tg;
    end
    @(negedge clk);
    mem_delay = dly;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
    #1;
    cyc = 0;
    while (!cpu_ready && cyc < 40) begin
      @(negedge clk); #1;
      cyc++;
    end
    check("latency", 32'(cyc), 32'(exp_cyc));
    @(posedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
    check("hit_cnt", 32'(hit_cnt), 32'(m_hit));
    check("miss_cnt", 32'(miss_cnt), 32'(m_miss));
  endtask

  task automatic flush_with_req(input logic [ADDR_W-1:0] addr);
    @(negedge clk);
    flush = 1'b1; cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = addr;
    #1;
    check("flush_ready", 32'(cpu_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; cpu_req = 1'b0;
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    check("flush_hit_cnt", 32'(hit_cnt), 32'(m_hit));
    check("flush_miss_cnt", 32'(miss_cnt), 32'(m_miss));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [ADDR_W-1:0] a;
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    flush = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    ref_mem[16'h1234] = 16'hBEEF; dev_mem[16'h1234] = 16'hBEEF;
    ref_mem[16'h5634] = 16'h1111; dev_mem[16'h5634] = 16'h1111;

    repeat (2) @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 16'h1234;
    #1;
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(mem_wdata), 32'd0);
    check("rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("rst_miss_cnt", 32'(miss_cnt), 32'd0);
    @(negedge clk);
    cpu_req = 1'b0; rst = 1'b0;

    // directed scenarios
    access(1'b0, 16'h1234, 16'h0, 3);        // cold miss
    access(1'b0, 16'h1234, 16'h0, 2);        // hit
    access(1'b0, 16'h5634, 16'h0, 2);        // conflict miss
    access(1'b0, 16'h1234, 16'h0, 1);        // evicted, misses again
    access(1'b0, 16'h5634, 16'h0, 4);
    access(1'b1, 16'h5634, 16'hA5A5, 3);     // write hit
    access(1'b0, 16'h5634, 16'h0, 2);        // reads back written data
    access(1'b1, 16'h0001, 16'h7777, 2);     // write miss, no allocate
    access(1'b0, 16'h0001, 16'h0, 2);        // still misses
    flush_with_req(16'h5634);
    access(1'b0, 16'h5634, 16'h0, 1);        // miss after flush

    // randomised traffic over a few tags and indices
    for (int i = 0; i < 80; i++) begin
      a = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 7))};
      case ($urandom_range(0, 9))
        0:       flush_with_req(a);
        1, 2, 3: access(1'b1, a, 16'($urandom), $urandom_range(1, 4));
        default: access(1'b0, a, 16'h0, $urandom_range(1, 4));
      endcase
    end

    // counter saturation
    access(1'b0, 16'h2222, 16'h0, 2);
    for (int i = 0; i < 21; i++) access(1'b0, 16'h2222, 16'h0, 1);
    check("hit_cnt_saturated", 32'(hit_cnt), 32'(CNT_MAX));

    // reset in the middle of a fill
    mem_hold = 1'b1;
    mem_q.push_back({1'b0, 16'h3344, 16'h0});
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h3344;
    repeat (3) @(negedge clk);
    #1;
    check("fill_mem_req", 32'(mem_req), 32'd1);
    check("fill_cpu_ready", 32'(cpu_ready), 32'd0);
    rst = 1'b1;
    #1;
    check("midfill_rst_mem_req", 32'(mem_req), 32'd0);
    check("midfill_rst_hit_cnt", 32'(hit_cnt), 32'd0);
    check("midfill_rst_miss_cnt", 32'(miss_cnt), 32'd0);
    foreach (m_valid[i]) m_valid[i] = 1'b0;
    m_hit = 0; m_miss = 0;
    @(negedge clk);
    cpu_req = 1'b0; rst = 1'b0; mem_hold = 1'b0;
    access(1'b0, 16'h2222, 16'h0, 2);        // previously cached, must miss

    repeat (3) @(negedge clk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("mem_q_drained", 32'(mem_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    bad++;
    $display("FAIL watchdog_timeout t=%0t required=finish", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
